// File: rtl/parser_pkg.sv
// Constants and state encoding shared by the MP3 frame loader and the frame feeder.
package parser_pkg;

  localparam int         MAX_FRAMES = 128;
  localparam logic [7:0] SYNC_BYTE0 = 8'hFF;
  localparam logic [2:0] SYNC_MASK1 = 3'b111;

  typedef enum logic [1:0] {HUNT, STORE, DONE} state_t;

  // Second byte of a frame header: top three bits set, but not another 0xFF.
  function automatic logic isSyncByte1(input logic [7:0] b);
    return (b[7:5] == SYNC_MASK1) && (b != SYNC_BYTE0);
  endfunction

endpackage

// File: rtl/bram_loader_if.sv
// Byte-stream input and data/index BRAM write ports of the MP3 frame loader.
interface bram_loader_if #(
  parameter int ADDR_W = 16
);

  logic [7:0]        axiid;
  logic              axiiv;
  logic              axiil;
  logic              data_wea;
  logic [ADDR_W-1:0] data_addra;
  logic [7:0]        data_dina;
  logic              idx_wea;
  logic [6:0]        idx_addra;
  logic [ADDR_W-1:0] idx_dina;
  logic [7:0]        frame_count;
  logic [ADDR_W-1:0] end_addr;
  logic              done;

  modport master (
    output axiid, axiiv, axiil,
    input  data_wea, data_addra, data_dina, idx_wea, idx_addra, idx_dina,
    input  frame_count, end_addr, done
  );

  modport slave (
    input  axiid, axiiv, axiil,
    output data_wea, data_addra, data_dina, idx_wea, idx_addra, idx_dina,
    output frame_count, end_addr, done
  );

endinterface

// File: rtl/mp3_sync_detect.sv
// Flags an 0xFF followed by a header byte across accepted bytes only, and
// remembers where the previous accepted byte was written.
module mp3_sync_detect #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  input  logic [7:0]        i_byte,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              o_sync,
  output logic [ADDR_W-1:0] o_prevAddr
);
  import parser_pkg::*;

  logic              r_prevFf;
  logic [ADDR_W-1:0] r_prevAddr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prevFf   <= 1'b0;
      r_prevAddr <= '0;
    end else if (i_valid) begin
      r_prevFf   <= (i_byte == SYNC_BYTE0);
      r_prevAddr <= i_addr;
    end
  end

  assign o_sync     = i_valid && r_prevFf && isSyncByte1(i_byte);
  assign o_prevAddr = r_prevAddr;

endmodule

// File: rtl/bram_loader.sv
// Stores an MP3 byte stream into the frame data BRAM from the first frame sync
// onward and records each frame's start address in the frame index BRAM.
module bram_loader #(
  parameter int DATA_DEPTH = 65536,
  parameter int MAX_FRAMES = parser_pkg::MAX_FRAMES
) (
  input  logic         clk,
  input  logic         rst,
  bram_loader_if.slave bus
);
  import parser_pkg::*;

  localparam int                ADDR_W      = $clog2(DATA_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(DATA_DEPTH - 1);
  localparam logic [7:0]        FRAME_LIMIT = 8'(MAX_FRAMES);

  state_t            r_state, w_nextState;
  logic [ADDR_W-1:0] r_wrPtr, w_wrPtr;
  logic [7:0]        r_frameCount, w_frameCount;
  logic [ADDR_W-1:0] r_endAddr, w_endAddr;
  logic              r_done;
  logic              r_dataWe, w_dataWe;
  logic [ADDR_W-1:0] r_dataAddr;
  logic [7:0]        r_dataDin;
  logic              r_idxWe, w_idxWe;
  logic [6:0]        r_idxAddr, w_idxAddr;
  logic [ADDR_W-1:0] r_idxDin, w_idxDin;

  logic              w_accept, w_isFf, w_sync, w_drop, w_atEnd;
  logic [ADDR_W-1:0] w_curAddr, w_prevAddr;

  assign w_accept  = bus.axiiv && (r_state != DONE);
  assign w_isFf    = (bus.axiid == SYNC_BYTE0);
  assign w_atEnd   = (r_wrPtr == LAST_ADDR);
  assign w_drop    = (r_state == STORE) && w_sync && (r_frameCount == FRAME_LIMIT);
  // While hunting only the candidate 0xFF (addr 0) or the header byte (addr 1) is ever stored.
  assign w_curAddr = (r_state == HUNT) ? (w_isFf ? '0 : ADDR_W'(1)) : r_wrPtr;

  mp3_sync_detect #(.ADDR_W(ADDR_W)) u_syncDetect (
    .clk        (clk),
    .rst        (rst),
    .i_valid    (w_accept),
    .i_byte     (bus.axiid),
    .i_addr     (w_curAddr),
    .o_sync     (w_sync),
    .o_prevAddr (w_prevAddr)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= HUNT;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      HUNT: begin
        if (w_accept && bus.axiil)     w_nextState = DONE;
        else if (w_accept && w_sync)   w_nextState = STORE;
      end
      STORE: begin
        if (w_accept && (w_drop || w_atEnd || bus.axiil)) w_nextState = DONE;
      end
      default: w_nextState = r_state;
    endcase
  end

  always_comb begin
    w_dataWe     = 1'b0;
    w_idxWe      = 1'b0;
    w_idxAddr    = r_frameCount[6:0];
    w_idxDin     = w_prevAddr;
    w_frameCount = r_frameCount;
    w_endAddr    = r_endAddr;
    w_wrPtr      = r_wrPtr;
    case (r_state)
      HUNT: begin
        if (w_accept && !bus.axiil) begin
          if (w_isFf) begin
            w_dataWe = 1'b1;
          end else if (w_sync) begin
            w_dataWe     = 1'b1;
            w_idxWe      = 1'b1;
            w_idxAddr    = 7'd0;
            w_idxDin     = '0;
            w_frameCount = 8'd1;
            w_wrPtr      = ADDR_W'(2);
          end
        end
      end
      STORE: begin
        if (w_accept) begin
          // Index full: the header byte is dropped and the frame's dangling 0xFF is cut off.
          if (w_drop) begin
            w_endAddr = w_prevAddr;
          end else begin
            w_dataWe = 1'b1;
            w_wrPtr  = r_wrPtr + 1'b1;
            if (w_sync) begin
              w_idxWe      = 1'b1;
              w_frameCount = r_frameCount + 8'd1;
            end
            if (w_atEnd)        w_endAddr = LAST_ADDR;
            else if (bus.axiil) w_endAddr = r_wrPtr + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr      <= '0;
      r_frameCount <= '0;
      r_endAddr    <= '0;
      r_done       <= 1'b0;
      r_dataWe     <= 1'b0;
      r_dataAddr   <= '0;
      r_dataDin    <= '0;
      r_idxWe      <= 1'b0;
      r_idxAddr    <= '0;
      r_idxDin     <= '0;
    end else begin
      r_wrPtr      <= w_wrPtr;
      r_frameCount <= w_frameCount;
      r_endAddr    <= w_endAddr;
      r_done       <= (w_nextState == DONE);
      r_dataWe     <= w_dataWe;
      r_dataAddr   <= w_curAddr;
      r_dataDin    <= bus.axiid;
      r_idxWe      <= w_idxWe;
      r_idxAddr    <= w_idxAddr;
      r_idxDin     <= w_idxDin;
    end
  end

  assign bus.data_wea    = r_dataWe;
  assign bus.data_addra  = r_dataAddr;
  assign bus.data_dina   = r_dataDin;
  assign bus.idx_wea     = r_idxWe;
  assign bus.idx_addra   = r_idxAddr;
  assign bus.idx_dina    = r_idxDin;
  assign bus.frame_count = r_frameCount;
  assign bus.end_addr    = r_endAddr;
  assign bus.done        = r_done;

endmodule
